// File: rtl/iot_io_pkg.sv
// Shared constants and helpers for the IoT input-conditioning blocks.
package iot_io_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int DEFAULT_WIDTH = 4;

  // Ceiling log2; clog2(1) = 0, so a 1-cycle debounce still gets a 1-bit counter (+1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iot_debounce_bit.sv
// One input bit: synchroniser chain, stability counter, debounced level and
// registered rise/fall strobes. rise_set/fall_set flag the accepting cycle.
module iot_debounce_bit
  import iot_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rise_set,
  output logic fall_set
);

  localparam int CW = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   accept;

  assign s        = sync_q[SYNC_STAGES-1];
  // The new level is taken on the cycle the counter has seen a full stable run.
  assign accept   = (s != db) && (cnt == CNT_LAST);
  assign rise_set = accept & s;
  assign fall_set = accept & ~s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      cnt        <= '0;
      db         <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], raw};
      rise_pulse <= rise_set;
      fall_pulse <= fall_set;
      if (s == db) begin
        cnt <= '0;
      end else if (accept) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/iot_input_conditioner.sv
// Input conditioner for the board's input PIO: per-bit debounce, sticky
// edge capture with per-bit clear, and a maskable level interrupt.
module iot_input_conditioner
  import iot_io_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] edge_capture,
  input  logic [WIDTH-1:0] capture_clear,
  input  logic [WIDTH-1:0] irq_mask,
  output logic             irq
);

  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;
  logic [WIDTH-1:0] edge_set;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    iot_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (raw_in[i]),
      .db        (db_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .rise_set  (rise_set[i]),
      .fall_set  (fall_set[i])
    );
  end

  always_comb begin
    edge_set = rise_set | fall_set;
    case (EDGE_TYPE)
      EDGE_RISE: edge_set = rise_set;
      EDGE_FALL: edge_set = fall_set;
      default:   edge_set = rise_set | fall_set;
    endcase
  end

  // Set is ORed in after the clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      edge_capture <= (edge_capture & ~capture_clear) | edge_set;
      irq          <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_iot_input_conditioner.sv
// Directed and randomized checks of iot_input_conditioner against a
// sliding-window reference model of the debounce, capture and irq rules.
module tb_iot_input_conditioner;
  import iot_io_pkg::*;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int SW = 4 * W + 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] db_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [W-1:0] edge_capture;
  logic [W-1:0] capture_clear;
  logic [W-1:0] irq_mask;
  logic         irq;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Scoreboard: expected {db, rise, fall, capture, irq} per clock.
  logic [SW-1:0] exp_q[$];
  // Raw inputs applied before each edge, newest first.
  logic [W-1:0]  raw_hist[$];
  logic [W-1:0]  m_db;
  logic [W-1:0]  m_cap;
  logic          m_irq;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  iot_input_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .EDGE_TYPE      (EDGE_ANY)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .db_out       (db_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .edge_capture (edge_capture),
    .capture_clear(capture_clear),
    .irq_mask     (irq_mask),
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    raw_hist = {};
    for (int i = 0; i < SS + DB; i++) raw_hist.push_front('0);
    exp_q = {};
    m_db  = '0;
    m_cap = '0;
    m_irq = 1'b0;
  endtask

  // A bit flips once the DB most recent synchronised samples all differ from it.
  task automatic model_step(input logic [W-1:0] r, input logic [W-1:0] c, input logic [W-1:0] m);
    logic [W-1:0] acc;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] smp;
    logic         nxt_irq;
    raw_hist.push_front(r);
    if (raw_hist.size() > SS + DB) void'(raw_hist.pop_back());
    acc = '1;
    for (int j = SS; j < SS + DB; j++) begin
      smp = raw_hist[j];
      acc = acc & (smp ^ m_db);
    end
    rise    = acc & ~m_db;
    fall    = acc & m_db;
    nxt_irq = |(m_cap & m);
    m_cap   = (m_cap & ~c) | rise | fall;
    m_db    = m_db ^ acc;
    m_irq   = nxt_irq;
    exp_q.push_back({m_db, rise, fall, m_cap, m_irq});
  endtask

  task automatic check_all(input string tag);
    logic [SW-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 4'd1, 4'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_db"},   db_out,       e[4*W:3*W+1]);
    chk({tag, "_rise"}, rise_pulse,   e[3*W:2*W+1]);
    chk({tag, "_fall"}, fall_pulse,   e[2*W:W+1]);
    chk({tag, "_cap"},  edge_capture, e[W:1]);
    chk({tag, "_irq"},  {3'b000, irq}, {3'b000, e[0]});
  endtask

  // driver: inputs change 1 time unit after an edge, outputs sampled 1 unit after the next
  task automatic step(input string tag, input logic [W-1:0] r, input logic [W-1:0] c,
                      input logic [W-1:0] m);
    raw_in        = r;
    capture_clear = c;
    irq_mask      = m;
    @(posedge clk);
    model_step(r, c, m);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_db"},   db_out,        '0);
    chk({tag, "_rise"}, rise_pulse,    '0);
    chk({tag, "_fall"}, fall_pulse,    '0);
    chk({tag, "_cap"},  edge_capture,  '0);
    chk({tag, "_irq"},  {3'b000, irq}, '0);
  endtask

  initial begin
    int lat;
    int cnt;
    logic seen;
    logic [W-1:0] r;
    logic [W-1:0] c;
    logic [W-1:0] m;

    // reset
    reset_n = 1'b0;
    raw_in = '0;
    capture_clear = '0;
    irq_mask = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // clean step on bit 0, latency SS + DB edges
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step("clean", 4'b0001, 4'b0000, 4'b0001);
      if (db_out[0] === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("clean_latency", 4'(lat), 4'(SS + DB));
    repeat (3) step("clean_hold", 4'b0001, 4'b0000, 4'b0001);

    // bounce on bit 1
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step("bounce", (k % 4 < 2) ? 4'b0011 : 4'b0001, 4'b0000, 4'b0001);
      if (db_out[1] === 1'b1) seen = 1'b1;
      if (rise_pulse[1] === 1'b1) cnt++;
    end
    chk("bounce_no_change", {3'b000, seen}, 4'b0000);
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      step("bounce_hold", 4'b0011, 4'b0000, 4'b0001);
      if (rise_pulse[1] === 1'b1) cnt++;
      if (lat == 0 && db_out[1] === 1'b1) lat = n;
    end
    chk("bounce_latency", 4'(lat), 4'(SS + DB));
    chk("bounce_one_rise", 4'(cnt), 4'd1);

    // clear race on bit 0
    repeat (8) step("race_fall", 4'b0010, 4'b0000, 4'b0001);
    step("race_preclear", 4'b0010, 4'b0001, 4'b0001);
    for (int i = 1; i <= 8; i++) begin
      step("race", 4'b0011, (i == SS + DB) ? 4'b0001 : 4'b0000, 4'b0001);
      if (i == SS + DB) chk("race_set_wins", {3'b000, edge_capture[0]}, 4'b0001);
    end
    step("race_clear", 4'b0011, 4'b0001, 4'b0001);
    chk("race_cleared", {3'b000, edge_capture[0]}, 4'b0000);
    step("race_irq", 4'b0011, 4'b0000, 4'b0001);
    chk("race_irq_drop", {3'b000, irq}, 4'b0000);

    // mask
    step("mask_clr", 4'b0011, 4'b1111, 4'b0000);
    repeat (8) step("mask_rise", 4'b0111, 4'b0000, 4'b0000);
    chk("mask_cap", edge_capture, 4'b0100);
    chk("mask_irq_off", {3'b000, irq}, 4'b0000);
    step("mask_on", 4'b0111, 4'b0000, 4'b0100);
    chk("mask_irq_on", {3'b000, irq}, 4'b0001);

    // multi-bit fall
    repeat (8) step("multi_rise", 4'b1111, 4'b0000, 4'b0000);
    step("multi_clr", 4'b1111, 4'b1111, 4'b0000);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step("multi_fall", 4'b0000, 4'b0000, 4'b0000);
      if (fall_pulse === 4'b1111) cnt++;
    end
    chk("multi_fall_once", 4'(cnt), 4'd1);
    chk("multi_cap", edge_capture, 4'b1111);

    // reset mid-count
    step("midrst_pre", 4'b0000, 4'b1111, 4'b0000);
    repeat (2) step("midrst_count", 4'b0001, 4'b0000, 4'b0000);
    reset_n = 1'b0;
    #1;
    check_zero("midrst_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("midrst_held");
    reset_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step("midrst_after", 4'b0001, 4'b0000, 4'b0000);
      if (db_out[0] === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("midrst_latency", 4'(lat), 4'(SS + DB));

    // randomized traffic
    r = 4'b0001;
    m = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 15) == 0) m = 4'($urandom_range(0, 15));
      step("rand", r, c, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
